// File: rtl/zx_mem_pkg.sv
// Shared constants and types for the SPRAM-backed Z80 byte memory.
package zx_mem_pkg;

    localparam int SPRAM_WORDS  = 16384;
    localparam int SPRAM_ADDR_W = 14;

    // MASKWREN enables one nibble per bit: lane 0 is DATAIN[7:0], lane 1 is DATAIN[15:8].
    localparam logic [3:0] MASK_LO  = 4'b0011;
    localparam logic [3:0] MASK_HI  = 4'b1100;
    localparam logic [3:0] MASK_ALL = 4'b1111;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    function automatic logic [3:0] lane_mask(input logic lane);
        return lane ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/up5k_spram_bank.sv
// One 16K x 16 SPRAM bank. Behaves like SB_SPRAM256KA: nibble write mask,
// one-cycle registered read, DATAOUT held while a write is in progress.
module up5k_spram_bank
    import zx_mem_pkg::*;
(
    input  logic                    clk,
    input  logic [SPRAM_ADDR_W-1:0] i_addr,
    input  logic [15:0]             i_din,
    input  logic [3:0]              i_mask,
    input  logic                    i_we,
    output logic [15:0]             o_dout
);

    // Power pins are tied: bank always selected, awake and powered.
    logic w_chipselect;
    logic w_standby;
    logic w_sleep;
    logic w_poweroff;
    logic w_active;

    assign w_chipselect = 1'b1;
    assign w_standby    = 1'b0;
    assign w_sleep      = 1'b0;
    assign w_poweroff   = 1'b1;
    assign w_active     = w_chipselect & ~w_standby & ~w_sleep & w_poweroff;

    logic [15:0] r_mem [SPRAM_WORDS];
    logic [15:0] r_dout;

    // Array access: masked nibble writes, otherwise registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (w_active) begin
            if (i_we) begin
                for (int n = 0; n < 4; n++) begin
                    if (i_mask[n]) begin
                        r_mem[i_addr][n*4 +: 4] <= i_din[n*4 +: 4];
                    end
                end
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/up5k_spram_bytemem.sv
// Byte-addressable store over 1..4 SPRAM banks with a valid/ready request
// port, single-cycle read return and a boot-time fill engine.
//
// state     | meaning
// FILL_IDLE | normal request service, waiting for fill_start
// FILL_RUN  | writing fill pattern to one word per cycle in every bank
// FILL_DONE | one-cycle fill_done pulse, requests accepted again
module up5k_spram_bytemem
    import zx_mem_pkg::*;
#(
    parameter int NUM_BANKS = 1,
    parameter int ADDR_W    = 15,
    parameter int FILL_TOP  = 16383
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rvalid,
    output logic [7:0]        rdata,
    input  logic              fill_start,
    input  logic [7:0]        fill_value,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam logic [SPRAM_ADDR_W-1:0] FILL_TOP_W = SPRAM_ADDR_W'(FILL_TOP);
    localparam logic [2:0]              NB_W       = 3'(NUM_BANKS);

    if (NUM_BANKS < 1 || NUM_BANKS > 4) begin : g_bad_banks
        $error("up5k_spram_bytemem: NUM_BANKS must be 1..4");
    end
    if (ADDR_W != 15 + $clog2(NUM_BANKS)) begin : g_bad_addr_w
        $error("up5k_spram_bytemem: ADDR_W must equal 15 + clog2(NUM_BANKS)");
    end

    fill_state_t             r_state;
    fill_state_t             w_state_nxt;
    logic                    w_fill_load;
    logic [SPRAM_ADDR_W-1:0] r_fill_cnt;
    logic [7:0]              r_fill_val;

    logic [1:0]              w_bank;
    logic                    w_bank_ok;
    logic                    w_accept;
    logic                    w_rd_accept;

    logic [SPRAM_ADDR_W-1:0] w_word_addr;
    logic [15:0]             w_din;
    logic [3:0]              w_mask;
    logic [NUM_BANKS-1:0]    w_we;
    logic [15:0]             w_dout [NUM_BANKS];

    logic                    r_rd_pend;
    logic                    r_rd_lane;
    logic [1:0]              r_rd_bank;
    logic                    r_rd_oob;
    logic [7:0]              r_rdata;
    logic [15:0]             w_rd_word;
    logic [7:0]              w_rd_byte;

    // Bank field only exists when there is more than one bank.
    if (ADDR_W > 15) begin : g_bank_field
        assign w_bank = 2'(req_addr[ADDR_W-1:15]);
    end else begin : g_single_bank
        assign w_bank = 2'b00;
    end

    assign w_bank_ok   = ({1'b0, w_bank} < NB_W);
    assign req_ready   = ~fill_busy;
    assign w_accept    = req_valid & req_ready;
    assign w_rd_accept = w_accept & ~req_we;

    // Fill state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= FILL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fill next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_load = 1'b0;
        fill_busy   = 1'b0;
        fill_done   = 1'b0;
        case (r_state)
            FILL_IDLE: begin
                if (fill_start) begin
                    w_fill_load = 1'b1;
                    w_state_nxt = FILL_RUN;
                end
            end
            FILL_RUN: begin
                fill_busy = 1'b1;
                if (r_fill_cnt == FILL_TOP_W) begin
                    w_state_nxt = FILL_DONE;
                end
            end
            FILL_DONE: begin
                fill_done   = 1'b1;
                w_state_nxt = FILL_IDLE;
            end
            default: w_state_nxt = FILL_IDLE;
        endcase
    end

    // Fill word counter and latched pattern; stops at FILL_TOP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fill_cnt <= '0;
            r_fill_val <= 8'h00;
        end else if (w_fill_load) begin
            r_fill_cnt <= '0;
            r_fill_val <= fill_value;
        end else if (r_state == FILL_RUN && r_fill_cnt != FILL_TOP_W) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    // Bank port sharing: the fill engine owns every bank while busy.
    assign w_word_addr = fill_busy ? r_fill_cnt : req_addr[14:1];
    assign w_din       = fill_busy ? {r_fill_val, r_fill_val} : {req_wdata, req_wdata};
    assign w_mask      = fill_busy ? MASK_ALL : lane_mask(req_addr[0]);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign w_we[b] = fill_busy |
                         (w_accept & req_we & w_bank_ok & (w_bank == 2'(b)));

        up5k_spram_bank u_bank (
            .clk    (clk),
            .i_addr (w_word_addr),
            .i_din  (w_din),
            .i_mask (w_mask),
            .i_we   (w_we[b]),
            .o_dout (w_dout[b])
        );
    end

    // Read return select: bank and lane captured at accept time.
    always_comb begin
        w_rd_word = 16'hFFFF;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_rd_bank == 2'(b)) begin
                w_rd_word = w_dout[b];
            end
        end
        if (r_rd_oob) begin
            w_rd_byte = 8'hFF;
        end else begin
            w_rd_byte = r_rd_lane ? w_rd_word[15:8] : w_rd_word[7:0];
        end
    end

    // Read tracking and held copy of the last returned byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_pend <= 1'b0;
            r_rd_lane <= 1'b0;
            r_rd_bank <= 2'b00;
            r_rd_oob  <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            r_rd_pend <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_lane <= req_addr[0];
                r_rd_bank <= w_bank;
                r_rd_oob  <= ~w_bank_ok;
            end
            if (r_rd_pend) begin
                r_rdata <= w_rd_byte;
            end
        end
    end

    // SPRAM data appears the cycle after issue, so the returned byte bypasses the hold register.
    assign rvalid = r_rd_pend;
    assign rdata  = r_rd_pend ? w_rd_byte : r_rdata;

endmodule

// File: tb/tb_up5k_spram_bytemem.sv
// Directed bench: two-bank build (FILL_TOP=15) for the main sequence,
// plus a three-bank build on the same stimulus for the out-of-range bank path.
module tb_up5k_spram_bytemem;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_we;
    logic [16:0] req_addr;
    logic [7:0]  req_wdata;
    logic        fill_start;
    logic [7:0]  fill_value;

    logic        ready2, rvalid2, busy2, done2;
    logic [7:0]  rdata2;
    logic        ready3, rvalid3, busy3, done3;
    logic [7:0]  rdata3;

    int n_checks = 0;
    int n_err    = 0;

    up5k_spram_bytemem #(.NUM_BANKS(2), .ADDR_W(16), .FILL_TOP(15)) u_dut2 (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (ready2),
        .req_we     (req_we),
        .req_addr   (req_addr[15:0]),
        .req_wdata  (req_wdata),
        .rvalid     (rvalid2),
        .rdata      (rdata2),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_busy  (busy2),
        .fill_done  (done2)
    );

    up5k_spram_bytemem #(.NUM_BANKS(3), .ADDR_W(17), .FILL_TOP(15)) u_dut3 (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (ready3),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rvalid     (rvalid3),
        .rdata      (rdata3),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_busy  (busy3),
        .fill_done  (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [16:0] addr, input logic [7:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("wr_no_rvalid", {31'd0, rvalid2}, 32'd1 - 32'd1);
    endtask

    task automatic do_read(input string tag, input bit use3, input logic [16:0] addr,
                           input logic [7:0] exp);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        if (use3) begin
            check({tag, "_rv"}, {31'd0, rvalid3}, 32'd1);
            check(tag, {24'd0, rdata3}, {24'd0, exp});
        end else begin
            check({tag, "_rv"}, {31'd0, rvalid2}, 32'd1);
            check(tag, {24'd0, rdata2}, {24'd0, exp});
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int rv_cnt;
        int ready_bad;

        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = 8'h00;
        fill_start = 1'b0;
        fill_value = 8'h00;

        #12;
        check("rst_ready",  {31'd0, ready2}, 32'd1);
        check("rst_rvalid", {31'd0, rvalid2}, 32'd0);
        check("rst_rdata",  {24'd0, rdata2}, 32'd0);
        check("rst_busy",   {31'd0, busy2}, 32'd0);
        check("rst_done",   {31'd0, done2}, 32'd0);
        resetn = 1'b1;
        tick();

        // Lane independence within one word.
        do_write(17'h00000, 8'hA5);
        do_write(17'h00001, 8'h5A);
        do_read("rd_lane0", 1'b0, 17'h00000, 8'hA5);
        do_read("rd_lane1", 1'b0, 17'h00001, 8'h5A);

        // rdata holds once rvalid drops.
        tick();
        check("hold_rvalid", {31'd0, rvalid2}, 32'd0);
        check("hold_rdata",  {24'd0, rdata2}, 32'h5A);

        // Same word offset in two banks must not alias.
        do_write(17'h00002, 8'h11);
        do_write(17'h08002, 8'h22);
        do_read("rd_bank0", 1'b0, 17'h00002, 8'h11);
        do_read("rd_bank1", 1'b0, 17'h08002, 8'h22);

        // Read issued the cycle right after a write sees the new byte.
        do_write(17'h00003, 8'h7E);
        do_read("rd_after_wr", 1'b0, 17'h00003, 8'h7E);

        // Markers: inside the fill range (must be cleared) and just past it (must survive).
        do_write(17'h0801F, 8'h66);
        do_write(17'h0001F, 8'h44);
        do_write(17'h1001F, 8'h44);
        do_write(17'h00020, 8'hC3);

        // Back-to-back reads, one per cycle.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 17'h00000;
        tick();
        check("b2b0_rv", {31'd0, rvalid2}, 32'd1);
        check("b2b0",    {24'd0, rdata2}, 32'hA5);
        req_addr = 17'h00001;
        tick();
        check("b2b1_rv", {31'd0, rvalid2}, 32'd1);
        check("b2b1",    {24'd0, rdata2}, 32'h5A);
        req_addr = 17'h08002;
        tick();
        req_valid = 1'b0;
        check("b2b2_rv", {31'd0, rvalid2}, 32'd1);
        check("b2b2",    {24'd0, rdata2}, 32'h22);
        tick();
        check("b2b_end_rv", {31'd0, rvalid2}, 32'd0);

        // Fill with 00, started in the same cycle as an accepted read.
        fill_value = 8'h00;
        fill_start = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 17'h00001;
        tick();
        fill_start = 1'b0;
        req_valid  = 1'b0;
        check("fill_rd_rv", {31'd0, rvalid2}, 32'd1);
        check("fill_rd",    {24'd0, rdata2}, 32'h5A);

        busy_cnt  = 0;
        done_cnt  = 0;
        rv_cnt    = 0;
        ready_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy2) busy_cnt++;
            if (busy2 && ready2) ready_bad++;
            if (done2) done_cnt++;
            if (i > 0 && rvalid2) rv_cnt++;
            if (i == 5) begin
                fill_start = 1'b1;
                fill_value = 8'hEE;
            end
            if (i == 6) begin
                fill_start = 1'b0;
                fill_value = 8'h00;
            end
            tick();
        end
        check("fill_busy_cycles", busy_cnt, 32'd16);
        check("fill_done_pulses", done_cnt, 32'd1);
        check("fill_ready_low",   ready_bad, 32'd0);
        check("fill_no_rvalid",   rv_cnt, 32'd0);
        check("fill_idle_busy",   {31'd0, busy2}, 32'd0);

        do_read("post_fill_0000", 1'b0, 17'h00000, 8'h00);
        do_read("post_fill_0001", 1'b0, 17'h00001, 8'h00);
        do_read("post_fill_801F", 1'b0, 17'h0801F, 8'h00);
        do_read("post_fill_1001F", 1'b1, 17'h1001F, 8'h00);
        do_read("post_fill_0020", 1'b0, 17'h00020, 8'hC3);

        // Reset two fill writes into a new fill with 55.
        fill_value = 8'h55;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("rf_busy", {31'd0, busy2}, 32'd1);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("rf_busy_rst",  {31'd0, busy2}, 32'd0);
        check("rf_ready_rst", {31'd0, ready2}, 32'd1);
        check("rf_rvalid_rst", {31'd0, rvalid2}, 32'd0);
        check("rf_rdata_rst", {24'd0, rdata2}, 32'd0);
        #2;
        resetn = 1'b1;
        tick();
        check("rf_idle", {31'd0, busy2}, 32'd0);
        do_read("rf_word0", 1'b0, 17'h00000, 8'h55);
        do_read("rf_word1", 1'b0, 17'h00003, 8'h55);
        do_read("rf_word2", 1'b0, 17'h00004, 8'h00);

        // Out-of-range bank on the three-bank build.
        do_write(17'h18002, 8'h77);
        do_read("oor_read",  1'b1, 17'h18002, 8'hFF);
        do_read("oor_bank0", 1'b1, 17'h00002, 8'h55);
        do_read("oor_bank1", 1'b1, 17'h08002, 8'h55);
        do_read("oor_bank2", 1'b1, 17'h10002, 8'h55);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
